cache_refill_responder: RTL and testbench

// - Memory-side responder for directly-mapped instruction caches: serves 64-bit line refill requests from N_PORTS caches.
// - Round-robin arbitration feeds one shared dual-port block RAM.
// - Host load port packs 32-bit program words into 64-bit lines.
// - On load exit, pulses cache_inval so all caches drop stale lines.

---
 rtl/cache_refill_responder_pkg.sv | 25 ++
 rtl/cache_refill_responder_if.sv | 45 ++++
 rtl/cache_refill_responder_rr_arbiter.sv | 38 +++
 rtl/cache_refill_responder.sv | 209 ++++++++++++++++++++
 tb/tb_cache_refill_responder.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_refill_responder_pkg.sv
// -----------------------------------------------------------------------------
// cache_refill_pkg
// Shared types and constants for the cache refill responder slice.
//   refill_state_t : responder FSM state (serve refills / host load / flush)
//   LINE_WIDTH     : width of one cache line held in the line RAM
//   WORD_WIDTH     : width of one host program word (half a line)
//   rr_next        : round-robin successor of a port index
// -----------------------------------------------------------------------------
package cache_refill_pkg;

    typedef enum logic [1:0] {
        S_SERVE = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2
    } refill_state_t;

    localparam int LINE_WIDTH = 64;
    localparam int WORD_WIDTH = 32;

    // Index that follows idx in an n-entry ring.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cache_refill_responder_if.sv
// -----------------------------------------------------------------------------
// cache_refill_responder_if
// Bundles the cache refill request/response bus and the host load bus.
//   req_valid/req_addr/req_ready : per-port line refill request (N_PORTS)
//   rsp_data/rsp_valid           : broadcast line data + one-hot response flag
//   load_en/load_valid/load_addr/load_data/load_ready : host word load port
//   cache_inval                  : one-cycle invalidate pulse to all caches
// Modports: master = caches + host side, slave = responder.
//
// Handshake semantics: a transfer happens in a cycle where both valid and ready
// are 1 (req_valid[i] & req_ready[i], load_valid & load_ready). Ready may depend
// combinationally on valid; valid must not depend on ready. A requester that
// sees no ready keeps valid and its address stable until it is granted.
// -----------------------------------------------------------------------------
interface cache_refill_responder_if
    import cache_refill_pkg::*;
#(
    parameter int N_PORTS         = 2,
    parameter int LINE_ADDR_WIDTH = 12
) ();

    logic [N_PORTS-1:0]                 req_valid;
    logic [N_PORTS*LINE_ADDR_WIDTH-1:0] req_addr;
    logic [N_PORTS-1:0]                 req_ready;
    logic [LINE_WIDTH-1:0]              rsp_data;
    logic [N_PORTS-1:0]                 rsp_valid;

    logic                               load_en;
    logic                               load_valid;
    logic [LINE_ADDR_WIDTH:0]           load_addr;
    logic [WORD_WIDTH-1:0]              load_data;
    logic                               load_ready;
    logic                               cache_inval;

    modport master (
        output req_valid, req_addr, load_en, load_valid, load_addr, load_data,
        input  req_ready, rsp_data, rsp_valid, load_ready, cache_inval
    );

    modport slave (
        input  req_valid, req_addr, load_en, load_valid, load_addr, load_data,
        output req_ready, rsp_data, rsp_valid, load_ready, cache_inval
    );

endinterface

// File: rtl/cache_refill_responder_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: grants the first requester found when
// scanning ptr, ptr+1, ... modulo N.
//   req     in  N   request vector
//   ptr     in  IW  scan start index (must be < N)
//   gnt     out N   one-hot grant (all zero when no request)
//   gnt_idx out IW  index of the granted requester (0 when no grant)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    int   scan;
    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        scan    = 0;
        for (int off = 0; off < N; off++) begin
            scan = (int'(ptr) + off) % N;
            if (!found && req[scan]) begin
                found     = 1'b1;
                gnt[scan] = 1'b1;
                gnt_idx   = IW'(scan);
            end
        end
    end

endmodule

// File: rtl/cache_refill_responder.sv
// -----------------------------------------------------------------------------
// cache_refill_responder
// Memory-side responder for directly-mapped instruction caches. N_PORTS caches
// request 64-bit lines; a round-robin arbiter picks one per cycle and the line
// is returned from a shared block RAM one cycle later. A host load port packs
// 32-bit words into lines; leaving load mode pulses cache_inval.
//
// Ports
//   clk        in   clock
//   rst        in   synchronous active-high reset (RAM contents are kept)
//   bus        slave modport of cache_refill_responder_if (refill + load bus)
//   state_dbg  out  current FSM state, for observation
//   stat_grants out N_PORTS*32 saturating per-port grant counters
//                   (present only when CACHE_REFILL_STATS_EN is defined)
//
// Optional feature macro: CACHE_REFILL_STATS_EN
// -----------------------------------------------------------------------------
module cache_refill_responder
    import cache_refill_pkg::*;
#(
    parameter int N_PORTS         = 2,
    parameter int LINE_ADDR_WIDTH = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    cache_refill_responder_if.slave   bus,
    output refill_state_t             state_dbg
`ifdef CACHE_REFILL_STATS_EN
    ,
    output logic [N_PORTS*32-1:0]     stat_grants
`endif
);

    localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int DEPTH = 1 << LINE_ADDR_WIDTH;

    refill_state_t state, next_state;

    logic [PTR_W-1:0]           rr_ptr;
    logic [N_PORTS-1:0]         arb_req;
    logic [N_PORTS-1:0]         gnt;
    logic [PTR_W-1:0]           gnt_idx;
    logic                       any_gnt;
    logic                       grant_en;
    logic [LINE_ADDR_WIDTH-1:0] raddr;

    logic [WORD_WIDTH-1:0]      hold;
    logic                       hold_vld;
    logic [LINE_ADDR_WIDTH-1:0] even_line;
    logic                       even_acc;

    logic                       ram_we;
    logic [LINE_ADDR_WIDTH-1:0] ram_waddr;
    logic [LINE_WIDTH-1:0]      ram_wdata;
    logic                       load_ready;

    logic [LINE_WIDTH-1:0]      rsp_data;
    logic [N_PORTS-1:0]         rsp_valid;
    logic                       cache_inval;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_SERVE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_SERVE: if (bus.load_en) next_state = S_LOAD;
            S_LOAD:  if (!bus.load_en) next_state = hold_vld ? S_FLUSH : S_SERVE;
            S_FLUSH: next_state = S_SERVE;
            default: next_state = S_SERVE;
        endcase
    end

    always_comb begin
        grant_en   = 1'b0;
        load_ready = 1'b0;
        even_acc   = 1'b0;
        ram_we     = 1'b0;
        ram_waddr  = '0;
        ram_wdata  = '0;
        case (state)
            // A rising load_en already blocks grants in the cycle it is seen.
            S_SERVE: grant_en = !bus.load_en;
            S_LOAD: begin
                load_ready = bus.load_valid;
                if (bus.load_valid && !bus.load_addr[0]) begin
                    even_acc = 1'b1;
                end
                if (bus.load_valid && bus.load_addr[0]) begin
                    ram_we    = 1'b1;
                    ram_waddr = bus.load_addr[LINE_ADDR_WIDTH:1];
                    // hold is zero when no even word preceded this odd one.
                    ram_wdata = {bus.load_data, hold};
                end
            end
            S_FLUSH: begin
                ram_we    = 1'b1;
                ram_waddr = even_line;
                ram_wdata = {{WORD_WIDTH{1'b0}}, hold};
            end
            default: ;
        endcase
    end

    assign state_dbg = state;

    // ---------------------------------------------------------- arbitration
    assign arb_req = bus.req_valid & {N_PORTS{grant_en}};

    rr_arbiter #(.N(N_PORTS), .IW(PTR_W)) u_arb (
        .req     (arb_req),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign any_gnt       = |gnt;
    assign bus.req_ready = gnt;

    always_comb begin
        raddr = bus.req_addr[int'(gnt_idx)*LINE_ADDR_WIDTH +: LINE_ADDR_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (any_gnt) begin
            rr_ptr <= PTR_W'(rr_next(int'(gnt_idx), N_PORTS));
        end
    end

    // ------------------------------------------------------ load half-word
    always_ff @(posedge clk) begin
        if (rst) begin
            hold      <= '0;
            hold_vld  <= 1'b0;
            even_line <= '0;
        end else if (even_acc) begin
            hold      <= bus.load_data;
            hold_vld  <= 1'b1;
            even_line <= bus.load_addr[LINE_ADDR_WIDTH:1];
        end else if (ram_we) begin
            // Every RAM write (odd word or flush) consumes the held half.
            hold      <= '0;
            hold_vld  <= 1'b0;
        end
    end

    // ------------------------------------------------------------ line RAM
    (* ram_style = "block" *) logic [LINE_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
    end

    // Reads only happen in S_SERVE and writes only outside it, so the two
    // ports never touch the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data <= '0;
        end else if (any_gnt) begin
            rsp_data <= mem[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid   <= '0;
            cache_inval <= 1'b0;
        end else begin
            rsp_valid   <= gnt;
            cache_inval <= (state != S_SERVE) && (next_state == S_SERVE);
        end
    end

    assign bus.rsp_data    = rsp_data;
    assign bus.rsp_valid   = rsp_valid;
    assign bus.load_ready  = load_ready;
    assign bus.cache_inval = cache_inval;

    // ---------------------------------------------------------- statistics
`ifdef CACHE_REFILL_STATS_EN
    logic [31:0] grant_cnt [N_PORTS];

    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_stats
        always_ff @(posedge clk) begin
            if (rst) begin
                grant_cnt[gi] <= '0;
            end else if (cache_inval) begin
                // The invalidate cycle restarts counting; a grant issued in
                // that same cycle is the first one of the new epoch.
                grant_cnt[gi] <= {31'd0, gnt[gi]};
            end else if (gnt[gi] && (grant_cnt[gi] != 32'hFFFF_FFFF)) begin
                grant_cnt[gi] <= grant_cnt[gi] + 32'd1;
            end
        end
        assign stat_grants[gi*32 +: 32] = grant_cnt[gi];
    end
`endif

endmodule

// File: tb/tb_cache_refill_responder.sv
module tb_cache_refill_responder;
    import cache_refill_pkg::*;

    localparam int NP  = 2;
    localparam int LAW = 12;

    // ------------------------------------------------ clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_refill_responder_if #(.N_PORTS(NP), .LINE_ADDR_WIDTH(LAW)) bus ();
    refill_state_t state_dbg;
`ifdef CACHE_REFILL_STATS_EN
    logic [NP*32-1:0] stat_grants;
`endif

    cache_refill_responder #(.N_PORTS(NP), .LINE_ADDR_WIDTH(LAW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
`ifdef CACHE_REFILL_STATS_EN
        ,
        .stat_grants (stat_grants)
`endif
    );

    // ------------------------------------------------ reference model
    int n_run  = 0;
    int n_fail = 0;

    logic [63:0] m_mem [int];          // lines the host has written
    int          m_ptr;                // next port to look at first
    logic [63:0] m_rsp;                // last delivered line
    logic [31:0] m_hold;               // pending low half of a line
    bit          m_hold_vld;
    int          m_even_line;
    int          m_grants [NP];
    logic [63:0] exp_q [$];            // expected responses, in grant order

    function automatic logic [NP-1:0] model_grant(input logic [NP-1:0] v, output int gi);
        logic [NP-1:0] g;
        g  = '0;
        gi = -1;
        for (int off = 0; off < NP; off++) begin
            int p;
            p = (m_ptr + off) % NP;
            if (gi < 0 && v[p]) begin
                gi   = p;
                g[p] = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic logic [63:0] model_line(input int line);
        return m_mem.exists(line) ? m_mem[line] : 64'h0;
    endfunction

    task automatic model_reset();
        m_ptr       = 0;
        m_rsp       = '0;
        m_hold      = '0;
        m_hold_vld  = 0;
        m_even_line = 0;
        for (int i = 0; i < NP; i++) m_grants[i] = 0;
        exp_q.delete();
    endtask

    // ------------------------------------------------ driver tasks
    task automatic drive_idle();
        bus.req_valid  = '0;
        bus.req_addr   = '0;
        bus.load_en    = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_addr  = '0;
        bus.load_data  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    // One S_SERVE cycle: drive requests, check the grant, then check the
    // response one cycle later. Leaves req_valid low afterwards.
    task automatic serve_cycle(input logic [NP-1:0] v, input logic [LAW-1:0] a0,
                               input logic [LAW-1:0] a1, input string tag,
                               output logic [NP-1:0] got_rdy, output logic [63:0] got_data);
        logic [NP-1:0] eg;
        int gi;
        bus.req_valid = v;
        bus.req_addr  = {a1, a0};
        eg = model_grant(v, gi);
        #1;
        got_rdy = bus.req_ready;
        n_run++;
        if (bus.req_ready !== eg) begin
            n_fail++;
            $display("FAIL %s req_ready: got %b expected %b", tag, bus.req_ready, eg);
        end
        if (gi >= 0) begin
            exp_q.push_back(model_line(int'((gi == 0) ? a0 : a1)));
            m_grants[gi]++;
            m_ptr = (gi + 1) % NP;
        end
        tick();
        bus.req_valid = '0;
        n_run++;
        if (bus.rsp_valid !== eg) begin
            n_fail++;
            $display("FAIL %s rsp_valid: got %b expected %b", tag, bus.rsp_valid, eg);
        end
        if (gi >= 0 && exp_q.size() > 0) m_rsp = exp_q.pop_front();
        got_data = bus.rsp_data;
        n_run++;
        if (bus.rsp_data !== m_rsp) begin
            n_fail++;
            $display("FAIL %s rsp_data: got %h expected %h", tag, bus.rsp_data, m_rsp);
        end
    endtask

    // Raise load_en while caches keep requesting: nothing may be granted.
    task automatic enter_load();
        bus.load_en   = 1'b1;
        bus.req_valid = '1;
        bus.req_addr  = {NP*LAW{1'b0}} | $urandom;
        #1;
        n_run++;
        if (bus.req_ready !== '0) begin
            n_fail++;
            $display("FAIL enter_load req_ready: got %b expected 0", bus.req_ready);
        end
        tick();
        n_run++;
        if (bus.rsp_valid !== '0 || bus.rsp_data !== m_rsp) begin
            n_fail++;
            $display("FAIL enter_load rsp: got %b/%h expected 0/%h", bus.rsp_valid, bus.rsp_data, m_rsp);
        end
        bus.req_valid = '0;
    endtask

    task automatic load_word(input logic [LAW:0] addr, input logic [31:0] data);
        bus.load_valid = 1'b1;
        bus.load_addr  = addr;
        bus.load_data  = data;
        bus.req_valid  = NP'($urandom);
        #1;
        n_run++;
        if (bus.load_ready !== 1'b1 || bus.req_ready !== '0) begin
            n_fail++;
            $display("FAIL load_word ready: got load_ready=%b req_ready=%b expected 1/0",
                     bus.load_ready, bus.req_ready);
        end
        if (addr[0] == 1'b0) begin
            m_hold      = data;
            m_hold_vld  = 1;
            m_even_line = int'(addr[LAW:1]);
        end else begin
            m_mem[int'(addr[LAW:1])] = {data, m_hold};
            m_hold     = '0;
            m_hold_vld = 0;
        end
        tick();
        bus.load_valid = 1'b0;
        bus.req_valid  = '0;
    endtask

    // Drop load_en; v/a0/a1 are the requests presented throughout the exit,
    // which may only be granted in the invalidate cycle.
    task automatic exit_load(input logic [NP-1:0] v, input logic [LAW-1:0] a0,
                             input logic [LAW-1:0] a1, output logic [63:0] got_data);
        logic [NP-1:0] r;
        bus.load_en   = 1'b0;
        bus.req_valid = v;
        bus.req_addr  = {a1, a0};
        #1;
        n_run++;
        if (bus.req_ready !== '0) begin
            n_fail++;
            $display("FAIL exit_load last load cycle req_ready: got %b expected 0", bus.req_ready);
        end
        tick();
        if (m_hold_vld) begin
            #1;
            n_run++;
            if (bus.req_ready !== '0 || bus.cache_inval !== 1'b0 || bus.load_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL exit_load flush cycle: got req_ready=%b inval=%b load_ready=%b expected 0/0/0",
                         bus.req_ready, bus.cache_inval, bus.load_ready);
            end
            m_mem[m_even_line] = {32'h0, m_hold};
            m_hold     = '0;
            m_hold_vld = 0;
            tick();
        end
        n_run++;
        if (bus.cache_inval !== 1'b1) begin
            n_fail++;
            $display("FAIL exit_load cache_inval pulse: got %b expected 1", bus.cache_inval);
        end
        for (int i = 0; i < NP; i++) m_grants[i] = 0;
        serve_cycle(v, a0, a1, "inval_cycle", r, got_data);
        n_run++;
        if (bus.cache_inval !== 1'b0) begin
            n_fail++;
            $display("FAIL exit_load cache_inval width: got %b expected 0", bus.cache_inval);
        end
    endtask

    // ------------------------------------------------ scenarios
    task automatic test_reset();
        do_reset();
        n_run++;
        if (state_dbg !== S_SERVE || bus.rsp_valid !== '0 || bus.rsp_data !== 64'h0 ||
            bus.cache_inval !== 1'b0 || bus.load_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset values: got state=%0d rsp_valid=%b rsp_data=%h inval=%b load_ready=%b expected 0/0/0/0/0",
                     state_dbg, bus.rsp_valid, bus.rsp_data, bus.cache_inval, bus.load_ready);
        end
    endtask

    task automatic test_load();
        logic [NP-1:0] r;
        logic [63:0]   d;
        enter_load();
        load_word(13'd0, 32'h11111111);
        load_word(13'd1, 32'h22222222);
        load_word(13'd2, 32'h33333333);
        load_word(13'd3, 32'h44444444);
        exit_load('0, '0, '0, d);
        serve_cycle(2'b01, 12'd0, 12'd0, "load_line0", r, d);
        n_run++;
        if (d !== 64'h2222222211111111) begin
            n_fail++;
            $display("FAIL load line0: got %h expected 2222222211111111", d);
        end
    endtask

    task automatic test_single_read();
        logic [NP-1:0] r;
        logic [63:0]   d;
        serve_cycle(2'b01, 12'd1, 12'd0, "single_read", r, d);
        n_run++;
        if (r !== 2'b01 || d !== 64'h4444444433333333) begin
            n_fail++;
            $display("FAIL single read: got %b/%h expected 01/4444444433333333", r, d);
        end
    endtask

    task automatic test_alternating();
        logic [NP-1:0] r;
        logic [63:0]   d;
        logic [NP-1:0] pat [4];
        pat[0] = 2'b01; pat[1] = 2'b10; pat[2] = 2'b01; pat[3] = 2'b10;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            serve_cycle(2'b11, LAW'($urandom_range(0, 1)), LAW'($urandom_range(0, 1)),
                        "alternating", r, d);
            n_run++;
            if (r !== pat[i]) begin
                n_fail++;
                $display("FAIL alternating grant %0d: got %b expected %b", i, r, pat[i]);
            end
        end
    endtask

    task automatic test_flush();
        logic [63:0] d;
        enter_load();
        load_word(13'd6, 32'hAAAA5555);
        exit_load(2'b01, 12'd3, 12'd0, d);
        n_run++;
        if (d !== 64'h00000000AAAA5555) begin
            n_fail++;
            $display("FAIL flush line3: got %h expected 00000000AAAA5555", d);
        end
    endtask

    task automatic test_load_rules();
        logic [NP-1:0] r;
        logic [63:0]   d;
        enter_load();
        load_word({12'd20, 1'b1}, 32'hC0DE0001);        // odd with no even
        load_word({12'd21, 1'b0}, 32'hDEAD0001);
        load_word({12'd21, 1'b0}, 32'hBEEF0002);        // last even wins
        load_word({12'd21, 1'b1}, 32'hCAFE0003);
        exit_load('0, '0, '0, d);
        serve_cycle(2'b10, 12'd0, 12'd20, "odd_only", r, d);
        n_run++;
        if (d !== 64'hC0DE0001_00000000) begin
            n_fail++;
            $display("FAIL odd without even: got %h expected c0de000100000000", d);
        end
        serve_cycle(2'b01, 12'd21, 12'd0, "even_twice", r, d);
        n_run++;
        if (d !== 64'hCAFE0003_BEEF0002) begin
            n_fail++;
            $display("FAIL back-to-back evens: got %h expected cafe0003beef0002", d);
        end
    endtask

    task automatic test_load_entry();
        logic [NP-1:0] r;
        logic [63:0]   d;
        serve_cycle(2'b11, 12'd0, 12'd1, "pre_load_grant", r, d);
        // load_en rises in the cycle after that grant; serve_cycle has
        // already checked its response.
        enter_load();
        for (int i = 0; i < 3; i++) begin
            bus.req_valid = '1;
            #1;
            n_run++;
            if (bus.req_ready !== '0) begin
                n_fail++;
                $display("FAIL load mode grant: got %b expected 0", bus.req_ready);
            end
            tick();
        end
        bus.req_valid = '0;
        exit_load('0, '0, '0, d);
    endtask

    task automatic test_reset_midload();
        logic [NP-1:0] r;
        logic [63:0]   d;
        enter_load();
        load_word({12'd5, 1'b0}, 32'h5A5A5A5A);
        rst = 1'b1;
        bus.load_en = 1'b0;
        tick();
        rst = 1'b0;
        model_reset();
        n_run++;
        if (bus.rsp_valid !== '0 || state_dbg !== S_SERVE || bus.cache_inval !== 1'b0) begin
            n_fail++;
            $display("FAIL reset mid-load: got rsp_valid=%b state=%0d inval=%b expected 0/0/0",
                     bus.rsp_valid, state_dbg, bus.cache_inval);
        end
        serve_cycle(2'b01, 12'd0, 12'd0, "ram_kept", r, d);
        enter_load();
        load_word({12'd5, 1'b1}, 32'h77777777);
        exit_load('0, '0, '0, d);
        serve_cycle(2'b10, 12'd0, 12'd5, "half_dropped", r, d);
        n_run++;
        if (d !== 64'h77777777_00000000) begin
            n_fail++;
            $display("FAIL pending half after reset: got %h expected 7777777700000000", d);
        end
    endtask

    task automatic test_random();
        logic [NP-1:0] r;
        logic [63:0]   d;
        enter_load();
        for (int k = 0; k < 16; k++) begin
            if ($urandom_range(0, 9) != 0) load_word({LAW'(32 + k), 1'b0}, $urandom);
            load_word({LAW'(32 + k), 1'b1}, $urandom);
        end
        exit_load('0, '0, '0, d);
        for (int i = 0; i < 60; i++) begin
            serve_cycle(NP'($urandom), LAW'($urandom_range(32, 47)), LAW'($urandom_range(32, 47)),
                        "random", r, d);
        end
    endtask

`ifdef CACHE_REFILL_STATS_EN
    task automatic test_stats();
        logic [NP-1:0] r;
        logic [63:0]   d;
        do_reset();
        for (int i = 0; i < 3; i++) serve_cycle(2'b10, 12'd0, 12'd1, "stats", r, d);
        n_run++;
        if (stat_grants[63:32] !== 32'd3 || stat_grants[31:0] !== 32'd0) begin
            n_fail++;
            $display("FAIL stat_grants: got %h expected 00000003_00000000", stat_grants);
        end
        test_random();
        n_run++;
        if (stat_grants[31:0] !== 32'(m_grants[0]) || stat_grants[63:32] !== 32'(m_grants[1])) begin
            n_fail++;
            $display("FAIL stat_grants random: got %h expected %h_%h", stat_grants,
                     32'(m_grants[1]), 32'(m_grants[0]));
        end
    endtask
`endif

    // ------------------------------------------------ sequence + report
    initial begin
        rst = 1'b1;
        drive_idle();
        model_reset();
        test_reset();
        test_load();
        test_single_read();
        test_alternating();
        test_flush();
        test_load_rules();
        test_load_entry();
        test_reset_midload();
        test_random();
`ifdef CACHE_REFILL_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
